// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard unit and the pipeline stages.
// Stages drive the requests; pipe_ctrl drives hold, flush and status.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             excp_valid;
    logic [31:0]      excp_vec;
    logic             perf_clr;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             wd_trip;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_vec, perf_clr,
        input  stall, flush, new_pc, stall_cnt, wd_trip
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_vec, perf_clr,
        output stall, flush, new_pc, stall_cnt, wd_trip
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: per-stage hold vector, exception flush,
// stall performance counter and a stuck-pipeline watchdog.
module pipe_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t           state;
    logic             flush_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      run_q;
    logic             wd_q;
    logic [5:0]       stall_c;

    // Hold vector is combinational so a stage can stop in its own cycle.
    always_comb begin
        stall_c = 6'b000000;
        if (!rst && state == RUN) begin
            if (bus.stallreq_mem)
                stall_c = 6'b011111;
            else if (bus.stallreq_ex)
                stall_c = 6'b001111;
            else if (bus.stallreq_id)
                stall_c = 6'b000111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            flush_q <= 1'b0;
            pc_q    <= 32'h0;
        end else begin
            unique case (state)
                RUN: begin
                    // A bus wait in mem defers the exception until it drains.
                    if (bus.excp_valid && !bus.stallreq_mem) begin
                        state   <= FLUSH;
                        flush_q <= 1'b1;
                        pc_q    <= bus.excp_vec;
                    end
                end
                FLUSH: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
                default: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr)
            cnt_q <= '0;
        else if (stall_c[0] && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 16'h0;
            wd_q  <= 1'b0;
        end else if (stall_c != 6'b000000) begin
            if (run_q < TO)
                run_q <= run_q + 16'h1;
            if (run_q == TO - 16'h1)
                wd_q <= 1'b1;
        end else begin
            run_q <= 16'h0;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.flush     = flush_q;
    assign bus.new_pc    = pc_q;
    assign bus.stall_cnt = cnt_q;
    assign bus.wd_trip   = wd_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with TIMEOUT=8 and a 4-bit stall counter.
// Inputs change 1ns after a rising edge; outputs are sampled before the next.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pipe_ctrl_if #(.CNT_W(4)) bus ();

    pipe_ctrl #(
        .TIMEOUT(8),
        .CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.stallreq_id  = 1'b1;
        bus.stallreq_ex  = 1'b1;
        bus.stallreq_mem = 1'b1;
        bus.excp_valid   = 1'b1;
        bus.excp_vec     = 32'hdead_beef;
        bus.perf_clr     = 1'b0;
        ticks(2);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_new_pc", bus.new_pc, 32'h0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("rst_wd", 32'(bus.wd_trip), 32'h0);

        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excp_valid   = 1'b0;
        rst = 1'b0;
        tick();

        // priority, combinational only (no edges in between)
        bus.stallreq_id  = 1'b1;
        bus.stallreq_ex  = 1'b1;
        bus.stallreq_mem = 1'b1;
        #1 chk("prio_all", 32'(bus.stall), 32'h1f);
        bus.stallreq_mem = 1'b0;
        #1 chk("prio_ex", 32'(bus.stall), 32'h0f);
        bus.stallreq_ex = 1'b0;
        #1 chk("prio_id", 32'(bus.stall), 32'h07);
        bus.stallreq_id = 1'b0;
        #1 chk("prio_none", 32'(bus.stall), 32'h00);

        // exception
        bus.excp_valid = 1'b1;
        bus.excp_vec   = 32'h0000_0040;
        #1 chk("excp_n_flush", 32'(bus.flush), 32'h0);
        tick();
        chk("excp_flush", 32'(bus.flush), 32'h1);
        chk("excp_pc", bus.new_pc, 32'h40);
        bus.stallreq_id = 1'b1;
        #1 chk("excp_stall0", 32'(bus.stall), 32'h0);
        bus.stallreq_id = 1'b0;
        bus.excp_valid  = 1'b0;
        bus.excp_vec    = 32'h0000_1234;
        tick();
        chk("excp_n2_flush", 32'(bus.flush), 32'h0);
        chk("excp_pc_hold", bus.new_pc, 32'h40);

        // deferral behind a memory wait
        bus.stallreq_mem = 1'b1;
        bus.excp_valid   = 1'b1;
        bus.excp_vec     = 32'h0000_0080;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("defer_stall", 32'(bus.stall), 32'h1f);
            chk("defer_flush", 32'(bus.flush), 32'h0);
            tick();
        end
        chk("defer_flush3", 32'(bus.flush), 32'h0);
        bus.stallreq_mem = 1'b0;
        tick();
        chk("defer_k1_flush", 32'(bus.flush), 32'h1);
        chk("defer_pc", bus.new_pc, 32'h80);
        chk("defer_cnt", 32'(bus.stall_cnt), 32'h3);
        bus.excp_valid = 1'b0;
        tick();
        chk("defer_k2_flush", 32'(bus.flush), 32'h0);

        // stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stallreq_id = 1'b1;
        ticks(10);
        bus.stallreq_id = 1'b0;
        chk("cnt_10", 32'(bus.stall_cnt), 32'd10);
        chk("wd_after_10", 32'(bus.wd_trip), 32'h1);
        bus.stallreq_ex = 1'b1;
        bus.perf_clr    = 1'b1;
        tick();
        chk("cnt_clr_wins", 32'(bus.stall_cnt), 32'h0);
        bus.perf_clr = 1'b0;
        ticks(20);
        bus.stallreq_ex = 1'b0;
        chk("cnt_sat", 32'(bus.stall_cnt), 32'd15);
        ticks(3);
        chk("wd_sticky", 32'(bus.wd_trip), 32'h1);

        // watchdog
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wd_rst", 32'(bus.wd_trip), 32'h0);
        bus.stallreq_id = 1'b1;
        ticks(7);
        bus.stallreq_id = 1'b0;
        tick();
        bus.stallreq_mem = 1'b1;
        ticks(7);
        bus.stallreq_mem = 1'b0;
        tick();
        chk("wd_7_1_7", 32'(bus.wd_trip), 32'h0);
        bus.stallreq_ex = 1'b1;
        ticks(7);
        chk("wd_7", 32'(bus.wd_trip), 32'h0);
        tick();
        chk("wd_8", 32'(bus.wd_trip), 32'h1);
        bus.stallreq_ex = 1'b0;
        ticks(5);
        chk("wd_hold", 32'(bus.wd_trip), 32'h1);

        // reset in the flush cycle
        bus.excp_valid = 1'b1;
        bus.excp_vec   = 32'h0000_00c0;
        tick();
        chk("mid_flush", 32'(bus.flush), 32'h1);
        rst = 1'b1;
        bus.excp_valid = 1'b0;
        tick();
        chk("mid_rst_flush", 32'(bus.flush), 32'h0);
        chk("mid_rst_pc", bus.new_pc, 32'h0);
        chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("mid_rst_wd", 32'(bus.wd_trip), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_flush", 32'(bus.flush), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
